// File: rtl/booth_pkg.sv
// Shared constants and state encoding for the sequential radix-2 Booth multiplier.
package booth_pkg;
  localparam int BOOTH_WIDTH = 8;
  localparam int BOOTH_CNT_W = $clog2(BOOTH_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/booth_datapath.sv
// Booth datapath: A/Qreg/q_m1/M registers, add/subtract of M and the arithmetic right shift.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] step_product_o
);
  // A and M carry one extra sign bit so that negating the most negative M cannot overflow.
  logic [WIDTH:0]   a_q, a_d, m_q, m_d, sum;
  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] qreg_q, qreg_d, qreg_sh;
  logic             qm1_q, qm1_d;

  always_comb begin
    case ({qreg_q[0], qm1_q})
      2'b01:   sum = a_q + m_q;
      2'b10:   sum = a_q - m_q;
      default: sum = a_q;
    endcase
    a_sh    = {sum[WIDTH], sum[WIDTH:1]};
    qreg_sh = {sum[0], qreg_q[WIDTH-1:1]};
  end

  always_comb begin
    a_d    = a_q;
    qreg_d = qreg_q;
    qm1_d  = qm1_q;
    m_d    = m_q;
    if (load_i) begin
      m_d    = {multiplicand_i[WIDTH-1], multiplicand_i};
      a_d    = '0;
      qreg_d = multiplier_i;
      qm1_d  = 1'b0;
    end else if (step_i) begin
      a_d    = a_sh;
      qreg_d = qreg_sh;
      qm1_d  = qreg_q[0];
    end
  end

  // Product as it will stand after the step in progress, so the top can register it on the final edge.
  assign step_product_o = {a_sh[WIDTH-1:0], qreg_sh};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_q    <= '0;
      qreg_q <= '0;
      qm1_q  <= 1'b0;
      m_q    <= '0;
    end else begin
      a_q    <= a_d;
      qreg_q <= qreg_d;
      qm1_q  <= qm1_d;
      m_q    <= m_d;
    end
  end
endmodule

// File: rtl/booth_top.sv
// Sequential signed Booth multiplier: controller FSM, step counter and registered product/valid.
module booth_top
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_WIDTH
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               enable_i,
  input  logic [WIDTH-1:0]   multiplicand_i,
  input  logic [WIDTH-1:0]   multiplier_i,
  output logic [2*WIDTH-1:0] booth_product_o,
  output logic               booth_valid_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;
  logic               valid_q, valid_d;
  logic               load, step;
  logic [2*WIDTH-1:0] step_product;

  booth_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .load_i         (load),
    .step_i         (step),
    .multiplicand_i (multiplicand_i),
    .multiplier_i   (multiplier_i),
    .step_product_o (step_product)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    product_d = product_q;
    valid_d   = valid_q;
    load      = 1'b0;
    step      = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (enable_i) begin
          load    = 1'b1;
          count_d = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // Dropping enable mid-computation abandons it; the old product stays visible.
        if (!enable_i) begin
          state_d = IDLE;
        end else begin
          step    = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST_STEP) begin
            product_d = step_product;
            valid_d   = 1'b1;
            state_d   = DONE;
          end
        end
      end
      DONE: begin
        if (!enable_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      count_q   <= '0;
      product_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      product_q <= product_d;
      valid_q   <= valid_d;
    end
  end

  assign booth_product_o = product_q;
  assign booth_valid_o   = valid_q;
endmodule

// File: tb/tb_booth_top.sv
// Randomized scoreboard bench for booth_top: signed product, latency, hold, abort and reset behaviour.
module tb_booth_top;
  import booth_pkg::*;

  localparam int W = 8;

  logic           clk_i = 1'b0;
  logic           reset_i = 1'b1;
  logic           enable_i = 1'b0;
  logic [W-1:0]   multiplicand_i = '0;
  logic [W-1:0]   multiplier_i = '0;
  logic [2*W-1:0] booth_product_o;
  logic           booth_valid_o;

  booth_top #(.WIDTH(W)) dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .enable_i        (enable_i),
    .multiplicand_i  (multiplicand_i),
    .multiplier_i    (multiplier_i),
    .booth_product_o (booth_product_o),
    .booth_valid_o   (booth_valid_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  int             due_q[$];
  logic [2*W-1:0] last_prod = '0;
  int             checks = 0;
  int             failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain signed integer multiply, truncated to the product width.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
    int p;
    p = int'($signed(m)) * int'($signed(q));
    return p[2*W-1:0];
  endfunction

  // ---------------- monitor ----------------
  logic           prev_valid = 1'b0;
  logic [2*W-1:0] held = '0;

  initial begin
    logic [2*W-1:0] e;
    int             due;
    forever begin
      @(posedge clk_i);
      #1;
      if (booth_valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", 32'(booth_valid_o), 32'd0);
        end else begin
          e   = exp_q.pop_front();
          due = due_q.pop_front();
          check("product", 32'(booth_product_o), 32'(e));
          check("latency", 32'(cyc), 32'(due));
        end
      end else if (booth_valid_o && prev_valid) begin
        check("hold_stable", 32'(booth_product_o), 32'(held));
      end
      prev_valid = booth_valid_o;
      held       = booth_product_o;
    end
  end

  // ---------------- drivers ----------------
  task automatic run_mul(input logic [W-1:0] m, input logic [W-1:0] q, input int hold, input bit drop);
    @(negedge clk_i);
    multiplicand_i = m;
    multiplier_i   = q;
    enable_i       = 1'b1;
    last_prod      = model(m, q);
    exp_q.push_back(last_prod);
    due_q.push_back(cyc + 1 + W);
    // Operands wander during CALC/DONE; only the captured pair may matter.
    for (int i = 0; i < W + hold; i++) begin
      @(negedge clk_i);
      multiplicand_i = W'($urandom);
      multiplier_i   = W'($urandom);
    end
    if (exp_q.size() != 0) begin
      check("valid_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      due_q.delete();
    end
    if (drop) begin
      enable_i = 1'b0;
      @(posedge clk_i);
      #1;
      check("valid_drop", 32'(booth_valid_o), 32'd0);
      check("product_kept", 32'(booth_product_o), 32'(last_prod));
    end
  endtask

  task automatic run_abort(input logic [W-1:0] m, input logic [W-1:0] q);
    @(negedge clk_i);
    multiplicand_i = m;
    multiplier_i   = q;
    enable_i       = 1'b1;
    repeat (4) @(negedge clk_i);
    enable_i = 1'b0;
    repeat (W + 2) @(negedge clk_i);
    check("abort_valid", 32'(booth_valid_o), 32'd0);
    check("abort_product", 32'(booth_product_o), 32'(last_prod));
  endtask

  task automatic check_reset_state(input string tag);
    @(posedge clk_i);
    #1;
    check({tag, "_product"}, 32'(booth_product_o), 32'd0);
    check({tag, "_valid"}, 32'(booth_valid_o), 32'd0);
    check({tag, "_state"}, 32'(dut.state_q), 32'(IDLE));
    last_prod = '0;
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] corner_m[6] = '{8'h80, 8'h7F, 8'h80, 8'hFF, 8'h00, 8'hFB};
  logic [W-1:0] corner_q[6] = '{8'h03, 8'h7F, 8'h80, 8'hFF, 8'hB3, 8'h07};

  initial begin
    reset_i  = 1'b1;
    enable_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("reset_product", 32'(booth_product_o), 32'd0);
    check("reset_valid", 32'(booth_valid_o), 32'd0);
    reset_i = 1'b0;

    // Directed corners, the first held high for several cycles in DONE.
    for (int i = 0; i < 6; i++) run_mul(corner_m[i], corner_q[i], (i == 0) ? 5 : 1, 1'b1);

    // Abort at step 4, then a fresh full multiply.
    run_abort(8'h25, 8'hC3);
    run_mul(8'h25, 8'hC3, 2, 1'b1);

    // Reset mid-CALC, then held with enable high: no start.
    @(negedge clk_i);
    multiplicand_i = 8'h11;
    multiplier_i   = 8'h22;
    enable_i       = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    check_reset_state("rst_calc");
    repeat (3) begin
      @(posedge clk_i);
      #1;
      check("rst_hold_valid", 32'(booth_valid_o), 32'd0);
    end
    @(negedge clk_i);
    reset_i  = 1'b0;
    enable_i = 1'b0;

    // Reset while in DONE.
    run_mul(8'hF0, 8'h0F, 2, 1'b0);
    reset_i = 1'b1;
    check_reset_state("rst_done");
    @(negedge clk_i);
    reset_i  = 1'b0;
    enable_i = 1'b0;

    // Random signed sweep.
    for (int n = 0; n < 1000; n++) begin
      run_mul(W'($urandom), W'($urandom), $urandom_range(1, 3), 1'b1);
    end

    repeat (3) @(negedge clk_i);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_top.md
# booth_top

Sequential radix-2 Booth multiplier for signed two's-complement operands: an 8-bit multiplicand times an 8-bit multiplier gives a 16-bit product. It is a self-contained arithmetic block with a level-sensitive enable and a product-valid flag. It is the top-level wrapper around a controller FSM and an add/subtract/shift datapath.

## Interface
- `WIDTH`, default 8: operand width. Product width is 2*`WIDTH`. Iteration count equals `WIDTH`.
- `clk_i` input, 1 bit: the single clock. All state changes on its rising edge.
- `reset_i` input, 1 bit: reset. Synchronous, active-high.
- `enable_i` input, 1 bit: level request to multiply. Sampled only on clock edges.
- `multiplicand_i` input, `WIDTH` bits: signed multiplicand M.
- `multiplier_i` input, `WIDTH` bits: signed multiplier Q.
- `booth_product_o` output, 2*`WIDTH` bits: signed product M*Q, driven from a register.
- `booth_valid_o` output, 1 bit: high while `booth_product_o` holds a completed result for the current request.

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- **IDLE**, when `enable_i`=1:
  - Latch M from `multiplicand_i`.
  - Load A=0, Qreg=`multiplier_i`, q_m1=0 and count=0.
  - Go to CALC.
- **CALC** runs one Booth step per cycle, selected by the pair {Qreg[0], q_m1}:
  - 01: A = A + M.
  - 10: A = A − M.
  - 00 or 11: A unchanged.
  - Then arithmetic-shift {A, Qreg, q_m1} right by 1, replicating the A MSB.
  - A is kept `WIDTH`+1 bits internally so that −128 and −(−128) do not overflow. The sign extension is dropped on output.
- **CALC exit**: after `WIDTH` steps, load `booth_product_o` = {A, Qreg} (low 2*`WIDTH` bits) and go to DONE.
- **DONE**:
  - `booth_valid_o`=1.
  - Product held stable while `enable_i`=1.
  - `enable_i`=0 returns to IDLE.
- **Operand capture**: operands are captured only on the IDLE→CALC transition. Input changes during CALC or DONE are ignored.
- **New multiply**: a new multiply requires `enable_i` low for at least one cycle, because DONE exits only via `enable_i`=0.
- **Abort**: `enable_i`=0 during CALC returns the FSM to IDLE. `booth_valid_o` stays 0 and `booth_product_o` keeps its previous value.
- **Signed wrap**: the result is exact over the full signed range (−128·−128 = +16384 fits in 16 bits). No saturation or overflow flag.

## Timing
- **Reset**: `reset_i`=1 on a clock edge forces state IDLE, `booth_product_o`=0, `booth_valid_o`=0 and clears all internal registers.
  - Reset overrides `enable_i` in the same cycle.
  - Reset mid-computation discards the operation.
- **Latency**: `enable_i` sampled high in IDLE at edge N, CALC steps at edges N+1 … N+`WIDTH`, and `booth_product_o`/`booth_valid_o` update at edge N+`WIDTH` (8 cycles after sampling).
  - Product and valid change on the same edge; valid never precedes a correct product.
- **Valid deassertion**: `booth_valid_o` falls on the edge where DONE samples `enable_i`=0. The product value remains.
- **Throughput**: one multiply per `WIDTH`+2 cycles minimum (including the IDLE cycle).

## Structure
- Package `booth_pkg` holds:
  - `WIDTH` default constant.
  - State enum {IDLE, CALC, DONE}.
  - Counter width `$clog2(WIDTH+1)`.
- Sub-module `booth_datapath` holds the A/Qreg/q_m1/M registers, the add/sub and the arithmetic shift, with load/step controls.
- `booth_top` contains the FSM, the counter and the output registers.

## Test plan
- Reset sequence, then `multiplicand_i`=−128, `multiplier_i`=3, `enable_i`=1 → `booth_product_o`=0xFE80 (−384) and `booth_valid_o`=1, exactly 8 cycles after `enable_i` is sampled high. The values hold while `enable_i` stays high.
- Signed operand corners:
  - 127×127 → 0x3F01.
  - −128×−128 → 0x4000.
  - −1×−1 → 0x0001.
  - 0×−77 → 0x0000.
  - −5×7 → 0xFFDD.
  - Lower `enable_i` between cases; valid must drop the cycle after.
- Change operands during CALC → result reflects the operands latched at start.
- Drop `enable_i` at CALC step 4 → valid never rises and the product is unchanged. Re-enable → a correct fresh result after a full 8 cycles.
- Assert `reset_i` mid-CALC and in DONE → outputs 0 on the next edge and the FSM in IDLE. Hold `reset_i` with `enable_i`=1 → no start.
- Random signed operand sweep (≥1000 pairs) against a signed reference model, also checking latency and that valid drops when `enable_i` is lowered.
